// File: rtl/bjx2_cpuid_rng_unit.sv
// CPUID / hardware-RNG unit: answers CPUID index queries and supplies RNG words with entropy accounting.
// Latency: the response is registered at the edge that samples reqValid and is visible in the following cycle.
// Backpressure: none. One request per cycle is accepted, and there is no stall.
//
// Ports:
//   clock, reset        system clock and synchronous active-high reset
//   timers[11:0]        timer taps; [0] is the noise source, and [11:8] is the timer-rate code
//   reqValid, index     request strobe and 5-bit CPUID index
//   respValid           high for exactly one cycle after each accepted request
//   resLo, resHi        result words, which keep their value between responses
module bjx2_cpuid_rng_unit #(
  parameter logic [63:0] FEATURES    = 64'h0,
  parameter logic [3:0]  CORE_ID     = 4'h0,
  parameter int          RNG_LANES   = 2,
  parameter int          RNG_WIDTH   = 32,
  parameter logic [63:0] RNG_SEED    = 64'h5A5A_C3C3_9696_0F0F,
  parameter int          REFILL_BITS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] timers,
  input  logic        reqValid,
  input  logic [4:0]  index,
  output logic        respValid,
  output logic [63:0] resLo,
  output logic [63:0] resHi
);

  localparam int         CAT_W    = RNG_LANES * RNG_WIDTH;
  localparam int         CHUNKS   = (CAT_W + 63) / 64;
  localparam int         PAD_W    = CHUNKS * 64;
  localparam logic [7:0] REFILL_B = 8'(REFILL_BITS);

  // An illegal configuration stops elaboration.
  if (RNG_LANES < 2 || RNG_LANES > 8 || RNG_WIDTH < 16 || RNG_WIDTH > 64 ||
      CAT_W < 64 || REFILL_BITS < 1 || REFILL_BITS > 255) begin : g_param_err
    $error("bjx2_cpuid_rng_unit: RNG parameters out of range");
  end

  logic [63:0]          r_cycle;
  logic [7:0]           r_ent;
  logic                 r_n1;
  logic                 r_n2;
  logic                 r_noise;
  logic [RNG_WIDTH-1:0] r_lane [RNG_LANES];
  logic [RNG_LANES-1:0] r_cc;

  logic                 w_read31;
  logic [RNG_LANES-1:0] w_bit;
  logic [7:0]           w_ent_base;
  logic [7:0]           w_ent_next;
  logic [PAD_W-1:0]     w_cat;
  logic [63:0]          w_fold;
  logic [63:0]          w_lo;
  logic [63:0]          w_hi;
  logic                 w_unused_timers;

  // Timer bits 7:1 are not used by this unit.
  assign w_unused_timers = ^timers[7:1];

  assign w_read31 = reqValid && (index == 5'd31);

  // Lane feedback. Each lane also mixes in its neighbour's registered
  // feedback bit, which couples the lanes.
  always_comb begin
    w_bit = '0;
    for (int i = 0; i < RNG_LANES; i++) begin
      w_bit[i] = r_lane[i][1] ^ r_lane[i][3] ^ r_lane[i][5] ^ r_lane[i][7] ^
                 r_noise ^ r_cc[(i + 1) % RNG_LANES] ^ 1'b1;
    end
  end

  // A read clears the count before this cycle's noise event is added.
  // The result is 1 when a read and an event happen in the same cycle.
  assign w_ent_base = w_read31 ? 8'h00 : r_ent;
  assign w_ent_next = (w_ent_base == 8'hFF) ? 8'hFF : (w_ent_base + {7'h00, r_noise});

  // The XOR-fold takes the lane concatenation in 64-bit chunks. The top chunk is zero-padded.
  always_comb begin
    w_cat = '0;
    for (int i = 0; i < RNG_LANES; i++) begin
      w_cat[i*RNG_WIDTH +: RNG_WIDTH] = r_lane[i];
    end
    w_fold = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      w_fold = w_fold ^ w_cat[k*64 +: 64];
    end
  end

  always_comb begin
    w_lo = 64'h0;
    w_hi = 64'h0;
    case (index)
      5'd0:  w_lo = 64'h2020324632584A42;
      5'd1:  w_lo = {FEATURES[63:8], CORE_ID, timers[11:8]};
      5'd2:  w_lo = {40'h0, REFILL_B, 4'h0, 4'(RNG_LANES), 8'(RNG_WIDTH)};
      5'd3:  w_lo = r_cycle;
      5'd31: begin
        w_lo = w_fold;
        w_hi = {48'h0, r_ent, 7'h0, (r_ent >= REFILL_B)};
      end
      default: begin
        w_lo = 64'h0;
        w_hi = 64'h0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      respValid <= 1'b0;
      resLo     <= 64'h0;
      resHi     <= 64'h0;
      r_cycle   <= 64'h0;
      r_ent     <= 8'h00;
      r_n1      <= 1'b0;
      r_n2      <= 1'b0;
      r_noise   <= 1'b0;
      r_cc      <= '0;
      for (int i = 0; i < RNG_LANES; i++) begin
        r_lane[i] <= RNG_SEED[RNG_WIDTH-1:0] + RNG_WIDTH'(i);
      end
    end else begin
      respValid <= reqValid;
      if (reqValid) begin
        resLo <= w_lo;
        resHi <= w_hi;
      end
      r_cycle <= r_cycle + 64'd1;
      r_ent   <= w_ent_next;
      r_n1    <= timers[0];
      r_n2    <= r_n1;
      r_noise <= r_n1 ^ r_n2;
      r_cc    <= w_bit;
      for (int i = 0; i < RNG_LANES; i++) begin
        r_lane[i] <= {w_bit[i], r_lane[i][RNG_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_bjx2_cpuid_rng_unit.sv
// Testbench for bjx2_cpuid_rng_unit: directed steps with a scoreboard of expected responses.
// Latency: the expectation pushed for the request at edge N is compared just after edge N.
// Backpressure: none. The DUT accepts one request per cycle.
module tb_bjx2_cpuid_rng_unit;

  localparam logic [63:0] P_FEATURES = 64'h0000_0000_0003_F900;
  localparam logic [3:0]  P_CORE_ID  = 4'h3;
  localparam int          N_LANES    = 2;
  localparam int          W_LANE     = 32;
  localparam logic [63:0] P_SEED     = 64'h5A5A_C3C3_9696_0F0F;
  localparam logic [7:0]  P_REFILL   = 8'd32;

  logic        clock;
  logic        reset;
  logic [11:0] timers;
  logic        reqValid;
  logic [4:0]  index;
  logic        respValid;
  logic [63:0] resLo;
  logic [63:0] resHi;

  bjx2_cpuid_rng_unit #(
    .FEATURES(P_FEATURES), .CORE_ID(P_CORE_ID), .RNG_LANES(N_LANES),
    .RNG_WIDTH(W_LANE), .RNG_SEED(P_SEED), .REFILL_BITS(32)
  ) dut (
    .clock(clock), .reset(reset), .timers(timers), .reqValid(reqValid),
    .index(index), .respValid(respValid), .resLo(resLo), .resHi(resHi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
  } resp_t;

  resp_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  rate = 4'hA;
  logic [63:0] last_lo, last_hi, obs_lo, obs_hi;

  // Reference state built from the behavioural equations
  logic [W_LANE-1:0] m_lane [N_LANES];
  logic [N_LANES-1:0] m_c;
  logic        m_n1, m_n2, m_noise;
  logic [7:0]  m_ent;
  logic [63:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input logic [63:0] obs,
                           input logic [63:0] lo, input logic [63:0] hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_LANES; i++) m_lane[i] = P_SEED[W_LANE-1:0] + W_LANE'(i);
    m_c = '0; m_n1 = 1'b0; m_n2 = 1'b0; m_noise = 1'b0; m_ent = 8'h0; m_cnt = 64'h0;
  endtask

  function automatic resp_t model_resp(input logic [4:0] ix);
    resp_t r;
    r.lo = 64'h0;
    r.hi = 64'h0;
    case (ix)
      5'd0: r.lo = 64'h2020324632584A42;
      5'd1: r.lo = {P_FEATURES[63:8], P_CORE_ID, rate};
      5'd2: r.lo = 64'h0000_0000_0020_0220;
      5'd3: r.lo = m_cnt;
      5'd31: begin
        for (int b = 0; b < N_LANES*W_LANE; b++)
          r.lo[b % 64] = r.lo[b % 64] ^ m_lane[b / W_LANE][b % W_LANE];
        r.hi[15:8] = m_ent;
        r.hi[0]    = (m_ent >= P_REFILL);
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_update(input logic rd, input logic t0);
    logic [N_LANES-1:0] b;
    logic [7:0] base;
    for (int i = 0; i < N_LANES; i++)
      b[i] = m_lane[i][1] ^ m_lane[i][3] ^ m_lane[i][5] ^ m_lane[i][7] ^
             m_noise ^ m_c[(i + 1) % N_LANES] ^ 1'b1;
    for (int i = 0; i < N_LANES; i++) m_lane[i] = {b[i], m_lane[i][W_LANE-1:1]};
    m_c = b;
    base = rd ? 8'h0 : m_ent;
    if (m_noise && base != 8'hFF) base = base + 8'd1;
    m_ent   = base;
    m_noise = m_n1 ^ m_n2;
    m_n2    = m_n1;
    m_n1    = t0;
    m_cnt   = m_cnt + 64'd1;
  endtask

  // One clock cycle. Drive the inputs, push the expected response, then compare just after the edge.
  task automatic step(input logic rq, input logic [4:0] ix, input logic t0);
    resp_t e;
    reqValid = rq;
    index    = ix;
    timers   = {rate, 7'h0, t0};
    if (rq) sb_q.push_back(model_resp(ix));
    model_update(rq && ix == 5'd31, t0);
    @(posedge clock);
    #1;
    chk("respValid", {63'h0, respValid}, {63'h0, rq});
    if (rq) begin
      e = sb_q.pop_front();
      obs_lo = resLo;
      obs_hi = resHi;
      chk($sformatf("resLo idx%0d", ix), resLo, e.lo);
      chk($sformatf("resHi idx%0d", ix), resHi, e.hi);
      last_lo = e.lo;
      last_hi = e.hi;
    end else begin
      chk("resLo held", resLo, last_lo);
      chk("resHi held", resHi, last_hi);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; reqValid = 1'b0; index = 5'd0; timers = {rate, 8'h0};
    @(posedge clock);
    @(posedge clock);
    #1;
    model_reset();
    sb_q.delete();
    chk("reset respValid", {63'h0, respValid}, 64'h0);
    chk("reset resLo", resLo, 64'h0);
    chk("reset resHi", resHi, 64'h0);
    last_lo = 64'h0;
    last_hi = 64'h0;
    reset = 1'b0;
  endtask

  initial begin
    logic tg;
    logic [63:0] rng_a;
    reset = 1'b1; reqValid = 1'b0; index = 5'd0; timers = 12'h0;
    last_lo = 64'h0; last_hi = 64'h0; obs_lo = 64'h0; obs_hi = 64'h0;
    model_reset();

    do_reset();
    // Cycle counter: requests issued 10 and 11 cycles after reset release
    for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd3, 1'b0);
    chk("cycle10", obs_lo, 64'd10);
    step(1'b1, 5'd3, 1'b0);
    chk("cycle11", obs_lo, 64'd11);

    // Signature, then a hold cycle, features, configuration, and the reserved indices
    step(1'b1, 5'd0, 1'b0);
    chk("signature", obs_lo, 64'h2020324632584A42);
    step(1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd1, 1'b0);
    chk("features", obs_lo, 64'h0000_0000_0003_F93A);
    step(1'b1, 5'd2, 1'b0);
    step(1'b1, 5'd7, 1'b0);
    step(1'b1, 5'd30, 1'b0);

    // No noise events so far
    step(1'b1, 5'd31, 1'b0);
    chk("entropy idle", obs_hi, 64'h0);

    // Toggled noise source, then a read
    tg = 1'b0;
    for (int i = 0; i < 42; i++) begin tg = ~tg; step(1'b0, 5'd0, tg); end
    tg = ~tg; step(1'b1, 5'd31, tg);
    chk_range("entropy 40", {56'h0, obs_hi[15:8]}, 64'd39, 64'd41);
    chk("fresh after fill", {63'h0, obs_hi[0]}, 64'h1);
    // An immediate re-read coincides with a noise event.
    tg = ~tg; step(1'b1, 5'd31, tg);
    chk_range("reread count", {56'h0, obs_hi[15:8]}, 64'd0, 64'd1);
    chk("reread fresh", {63'h0, obs_hi[0]}, 64'h0);
    tg = ~tg; step(1'b1, 5'd31, tg);
    chk("coincident event count", {56'h0, obs_hi[15:8]}, 64'd1);

    for (int i = 0; i < 300; i++) begin tg = ~tg; step(1'b0, 5'd0, tg); end
    step(1'b1, 5'd31, 1'b0);
    chk("entropy saturated", {56'h0, obs_hi[15:8]}, 64'd255);

    // Deterministic RNG values with the noise source held at 0
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd31, 1'b0);
    rng_a = obs_lo;
    step(1'b1, 5'd31, 1'b0);
    checks++;
    assert (rng_a !== obs_lo) else begin
      errors++;
      $error("FAIL rng differ observed=%h expected!=%h", obs_lo, rng_a);
    end

    // Reset asserted at the same edge as a request drops that response.
    reqValid = 1'b1; index = 5'd0; reset = 1'b1;
    @(posedge clock);
    #1;
    chk("reset mid-request respValid", {63'h0, respValid}, 64'h0);
    reset = 1'b0;
    model_reset();
    sb_q.delete();
    last_lo = 64'h0; last_hi = 64'h0;
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
